// File: rtl/um_linebuf_ctrl_if.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | um_linebuf_ctrl_if : port bundle for one 2048x24 line-buffer memory          |
// | Rev 1.0                                                                      |
// +----------------------------------------------------------------------------+
interface um_linebuf_ctrl_if #(
    parameter int AW = 11
) ();
    logic          cs;
    logic          web;
    logic          re;
    logic [AW-1:0] raddr;
    logic [AW-1:0] waddr;
    logic [23:0]   din;
    logic [23:0]   dout;

    modport master (
        output cs, web, re, raddr, waddr, din,
        input  dout
    );

    modport slave (
        input  cs, web, re, raddr, waddr, din,
        output dout
    );
endinterface
`default_nettype wire

// File: rtl/um_linebuf_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | um_linebuf_ctrl : cascaded two-line-buffer sequencer producing 3-tap columns |
// | Rev 1.0                                                                      |
// +----------------------------------------------------------------------------+
module um_linebuf_ctrl #(
    parameter int H_ACT = 1920,
    parameter int V_ACT = 1080,
    parameter int AW    = 11
) (
    input  wire               clk,
    input  wire               rst_n,
    input  wire               en,
    input  wire  [26:0]       dp_in,
    um_linebuf_ctrl_if.master m1,
    um_linebuf_ctrl_if.master m2,
    output logic [23:0]       tap0,
    output logic [23:0]       tap1,
    output logic [23:0]       tap2,
    output logic              tap1_vld,
    output logic              tap2_vld,
    output logic [2:0]        sync_out,
    output logic [AW-1:0]     x_pos,
    output logic [10:0]       y_pos,
    output logic              short_line
);

    localparam logic [AW-1:0] C_X_LAST = AW'(H_ACT - 1);
    localparam logic [10:0]   C_Y_LAST = 11'(V_ACT - 1);

    logic          w_den;
    logic          w_vsync;
    logic [10:0]   w_y_next;
    logic          w_cs;
    logic          w_rd;
    logic          w_wr;

    logic [AW-1:0] r_x;
    logic [10:0]   r_y;
    logic          r_short;
    logic          r_stale;
    logic [AW-1:0] r_x_d1;
    logic [10:0]   r_y_d1;
    logic [23:0]   r_px_d1;
    logic [2:0]    r_sync_d1;
    logic          r_den_d1;
    logic          r_tap1_vld;
    logic          r_tap2_vld;

    assign w_den    = dp_in[24];
    assign w_vsync  = dp_in[26];
    assign w_y_next = (r_y == C_Y_LAST) ? 11'd0 : r_y + 11'd1;

    // Active-pixel position; den has priority over vsync
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_x     <= '0;
            r_y     <= '0;
            r_short <= 1'b0;
        end else if (en) begin
            if (w_den) begin
                if (r_x == C_X_LAST) begin
                    r_x <= '0;
                    r_y <= w_y_next;
                end else begin
                    r_x <= r_x + AW'(1);
                end
            end else if (w_vsync) begin
                r_x <= '0;
                r_y <= '0;
            end else if (r_x != '0) begin
                r_x     <= '0;
                r_y     <= w_y_next;
                r_short <= 1'b1;
            end
        end
    end

    // Any disabled cycle corrupts the buffered lines until a fresh frame starts
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_stale <= 1'b0;
        end else if (!en) begin
            r_stale <= 1'b1;
        end else if (!w_den && w_vsync) begin
            r_stale <= 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_x_d1     <= '0;
            r_y_d1     <= '0;
            r_px_d1    <= '0;
            r_sync_d1  <= '0;
            r_den_d1   <= 1'b0;
            r_tap1_vld <= 1'b0;
            r_tap2_vld <= 1'b0;
        end else begin
            r_x_d1     <= r_x;
            r_y_d1     <= r_y;
            r_px_d1    <= dp_in[23:0];
            r_sync_d1  <= dp_in[26:24];
            r_den_d1   <= w_den & en;
            r_tap1_vld <= w_den & en & ~r_stale & (r_y >= 11'd1);
            r_tap2_vld <= w_den & en & ~r_stale & (r_y >= 11'd2);
        end
    end

    // Reads at cycle t, writes of the same column at t+1: addresses never collide
    assign w_cs = en & rst_n;
    assign w_rd = w_den & en & rst_n;
    assign w_wr = r_den_d1 & en;

    assign m1.cs    = w_cs;
    assign m1.re    = w_rd;
    assign m1.raddr = r_x;
    assign m1.web   = ~w_wr;
    assign m1.waddr = r_x_d1;
    assign m1.din   = r_px_d1;

    assign m2.cs    = w_cs;
    assign m2.re    = w_rd;
    assign m2.raddr = r_x;
    assign m2.web   = ~w_wr;
    assign m2.waddr = r_x_d1;
    assign m2.din   = w_wr ? m1.dout : 24'd0;

    assign tap0       = r_px_d1;
    assign tap1       = r_tap1_vld ? m1.dout : 24'd0;
    assign tap2       = r_tap2_vld ? m2.dout : 24'd0;
    assign tap1_vld   = r_tap1_vld;
    assign tap2_vld   = r_tap2_vld;
    assign sync_out   = r_sync_d1;
    assign x_pos      = r_x_d1;
    assign y_pos      = r_y_d1;
    assign short_line = r_short;

endmodule
`default_nettype wire

// File: doc/um_linebuf_ctrl.md
Name: um_linebuf_ctrl

Overview:
- Sequences the two MEM2048X24 line buffers (mem1, mem2) feeding the unsharp-mask stage.
- Tracks the active-pixel position from DEN/VSYNC and issues cascaded read/write commands to both memories every active pixel.
- Presents a vertically aligned 3-tap column: current line, line y-1 and line y-2, plus tap-valid flags and delayed sync.
- Sits between the IG stage output and the UM filter.

Parameters:
- H_ACT, 1920, active pixels per line; must be ≤ 2048.
- V_ACT, 1080, active lines per frame.
- AW, 11, memory address width.

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- en  in  1  controller enable (UM function on)
- dp_in  in  27  {vsync, hsync, den, R[7:0], G[7:0], B[7:0]} from the previous stage
- m1_cs, m2_cs  out  1  memory chip select
- m1_web, m2_web  out  1  write enable, active low
- m1_re, m2_re  out  1  read enable
- m1_raddr, m2_raddr  out  AW  read address
- m1_waddr, m2_waddr  out  AW  write address
- m1_din, m2_din  out  24  write data
- m1_dout, m2_dout  in  24  read data; valid one cycle after a read with RE=1
- tap0, tap1, tap2  out  24  pixel at (x, y), (x, y-1), (x, y-2)
- tap1_vld, tap2_vld  out  1  tap1/tap2 hold real image data
- sync_out  out  3  dp_in[26:24] delayed to align with the taps
- x_pos  out  AW  column of the current taps
- y_pos  out  11  row of the current taps
- short_line  out  1  sticky error flag

Behaviour:
- Reset (async, rst_n=0):
  - All registers clear.
  - tap0/1/2=0, tap1_vld=tap2_vld=0, sync_out=0, x_pos=y_pos=0, short_line=0.
  - Memory controls are forced to cs=0, web=1, re=0; addresses and din are 0.
- Counters x, y (advance only when en=1):
  - When den=1: x increments. At x=H_ACT-1, x wraps to 0 and y increments. At y=V_ACT-1, y wraps to 0.
  - When den falls with x≠0: x←0, y increments, short_line←1. short_line is sticky until reset.
  - vsync=1 with den=0: x←0, y←0. If den and vsync are both 1, den wins.
- Read, cycle t (den&en=1):
  - m1_re=m2_re=1.
  - m1_raddr=m2_raddr=x.
- Write, cycle t+1 (den_d1&en=1), cascade:
  - m1_web=0, m1_waddr=x_d1, m1_din=pixel_d1.
  - m2_web=0, m2_waddr=x_d1, m2_din=m1_dout.
  - Read and write addresses always differ by one cycle of x, so there is no same-address collision. mem1 ends up holding line y-1 and mem2 holds line y-2.
- cs: m1_cs=m2_cs=en.
- Control outputs: combinational from registered state and den. Everything else is registered.
- Latency: 1 cycle. tap0=pixel_d1, tap1=m1_dout, tap2=m2_dout. sync_out, x_pos and y_pos come from the same t+1 registers.
- Validity:
  - tap1_vld=1 when y_d1≥1 and den_d1. tap2_vld=1 when y_d1≥2 and den_d1.
  - An invalid tap outputs 0 rather than stale memory contents.
  - Frame wrap (y→0) clears validity.
- en=0:
  - No memory accesses.
  - tap0 passes dp_in[23:0] delayed by 1 cycle; tap1=tap2=0; valids=0.
  - Counters hold, and resume from 0 after the next vsync.
- en deasserted mid-line: the current line's writes stop, and that line is treated as invalid. Validity restarts after vsync.
- Reset mid-frame: immediate clear, with no pending writes.

Test Plan:
- Reset with en=1, 3 lines of H_ACT=8 (test parameter), pixel = {y,x,8'h00} -> tap1 on line 2, x=3 is {1,3,00}; tap2 on line 2 is {0,3,00}; tap2_vld first rises at y_pos=2.
- Line 0 -> tap1=tap2=0, both valids 0; m1_web=0 on cycles x+1 with m1_waddr=x_d1.
- Check every active cycle -> read and write addresses to the same memory never coincide in one cycle; each cycle's waddr equals the previous cycle's raddr.
- den drops at x=5 (H_ACT=8) -> short_line=1 (sticky); next line starts at x=0, y+1.
- vsync pulse mid-frame -> x=y=0, valids 0 on the next line; m1_dout from the old frame must not appear on tap1.
- en=0 for a full line -> cs=0, web=1, re=0 throughout; tap0 equals dp_in[23:0] delayed 1 cycle; assert rst_n=0 mid-line -> all outputs 0 asynchronously.
